// File: rtl/synaptic_core_pkg.sv
// Shared encodings and the saturation helper for the synaptic read-modify-write core.
package synaptic_core_pkg;

  localparam logic [1:0] MODE_ACCUM = 2'b00;
  localparam logic [1:0] MODE_APPLY = 2'b01;
  localparam logic [1:0] MODE_CLEAR = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  // Clamp a signed value to the range of a w-bit two's complement number.
  function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/synaptic_core_rmw_if.sv
// Controller / neuron-core / inference-reader facing signals of the synaptic core.
interface synaptic_core_rmw_if #(
  parameter int POST_NEUR_PARALLEL = 4,
  parameter int WEIGHT_WIDTH       = 8,
  parameter int CNT_WIDTH          = 7,
  parameter int ADDR_WIDTH         = 16
);
  // Handshakes: start is a one-cycle request taken only while busy=0 (no ready; dropped
  // otherwise), done is a one-cycle completion pulse; rd_req is taken only when idle and
  // start=0, and rd_valid answers it exactly one cycle later. post_s_cnt must be valid
  // the cycle after post_idx is presented.
  logic                                   start;
  logic [1:0]                             mode;
  logic                                   is_pos;
  logic [ADDR_WIDTH-1:0]                  base_addr;
  logic [ADDR_WIDTH-1:0]                  word_cnt;
  logic [CNT_WIDTH-1:0]                   pre_s_cnt;
  logic [ADDR_WIDTH-1:0]                  post_idx;
  logic [CNT_WIDTH*POST_NEUR_PARALLEL-1:0] post_s_cnt;
  logic                                   busy;
  logic                                   done;
  logic                                   err;
  logic                                   rd_req;
  logic [ADDR_WIDTH-1:0]                  rd_addr;
  logic                                   rd_valid;
  logic [WEIGHT_WIDTH*POST_NEUR_PARALLEL-1:0] rd_data;
  logic [1:0]                             dbg_state;

  modport master (
    output start, mode, is_pos, base_addr, word_cnt, pre_s_cnt, post_s_cnt, rd_req, rd_addr,
    input  post_idx, busy, done, err, rd_valid, rd_data, dbg_state
  );

  modport slave (
    input  start, mode, is_pos, base_addr, word_cnt, pre_s_cnt, post_s_cnt, rd_req, rd_addr,
    output post_idx, busy, done, err, rd_valid, rd_data, dbg_state
  );

endinterface

// File: rtl/rmw_lane.sv
// Per-lane combinational update: STDP gradient accumulate, weight apply, gradient clear.
module rmw_lane
  import synaptic_core_pkg::*;
#(
  parameter int WEIGHT_WIDTH = 8,
  parameter int GRAD_WIDTH   = 8,
  parameter int CNT_WIDTH    = 7,
  parameter int PROD_SHIFT   = 4,
  parameter int LR_SHIFT     = 2
) (
  input  logic [1:0]                     mode,
  input  logic                           is_pos,
  input  logic [CNT_WIDTH-1:0]           pre_cnt,
  input  logic [CNT_WIDTH-1:0]           post_cnt,
  input  logic signed [WEIGHT_WIDTH-1:0] w_in,
  input  logic signed [GRAD_WIDTH-1:0]   g_in,
  output logic signed [WEIGHT_WIDTH-1:0] w_out,
  output logic signed [GRAD_WIDTH-1:0]   g_out
);

  localparam int PW = 2 * CNT_WIDTH;
  localparam int EW = GRAD_WIDTH + PW + 1;

  logic [PW-1:0]                 prod;
  logic [PW-1:0]                 d;
  logic signed [EW-1:0]          g_ext;
  logic signed [EW-1:0]          d_ext;
  logic signed [EW-1:0]          acc;
  logic signed [GRAD_WIDTH-1:0]  g_lr;
  logic signed [31:0]            w_sum;

  assign prod  = {{CNT_WIDTH{1'b0}}, pre_cnt} * {{CNT_WIDTH{1'b0}}, post_cnt};
  assign d     = prod >> PROD_SHIFT;
  // Wide enough that neither the add nor the subtract can overflow before clamping.
  assign g_ext = {{(EW-GRAD_WIDTH){g_in[GRAD_WIDTH-1]}}, g_in};
  assign d_ext = {{(EW-PW){1'b0}}, d};
  assign acc   = is_pos ? g_ext + d_ext : g_ext - d_ext;
  assign g_lr  = g_in >>> LR_SHIFT;
  assign w_sum = 32'(w_in) + 32'(g_lr);

  always_comb begin
    w_out = w_in;
    g_out = '0;
    case (mode)
      MODE_ACCUM: g_out = GRAD_WIDTH'(sat(32'(acc), GRAD_WIDTH));
      MODE_APPLY: w_out = WEIGHT_WIDTH'(sat(w_sum, WEIGHT_WIDTH));
      default:    g_out = '0;
    endcase
  end

endmodule

// File: rtl/sram_synaptic_sim.sv
// Single-port synaptic SRAM model: registered read, write-enable priority, X beyond DEPTH.
module sram_synaptic_sim #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 50176,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  cs,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      d,
  output logic [WIDTH-1:0]      q
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) begin
        if (32'(addr) < DEPTH) mem[addr] <= d;
      end else begin
        q <= (32'(addr) < DEPTH) ? mem[addr] : 'x;
      end
    end
  end

endmodule

// File: rtl/synaptic_core_rmw.sv
// Synaptic core: weight/gradient banks swept by a RD/WR sequencer, plus an idle-time read port.
module synaptic_core_rmw
  import synaptic_core_pkg::*;
#(
  parameter int POST_NEUR_PARALLEL = 4,
  parameter int WEIGHT_WIDTH       = 8,
  parameter int GRAD_WIDTH         = 8,
  parameter int CNT_WIDTH          = 7,
  parameter int ADDR_WIDTH         = 16,
  parameter int DEPTH              = 50176,
  parameter int PROD_SHIFT         = 4,
  parameter int LR_SHIFT           = 2
) (
  input logic               clk,
  input logic               rst,
  synaptic_core_rmw_if.slave bus
);

  localparam int WW = WEIGHT_WIDTH * POST_NEUR_PARALLEL;
  localparam int GW = GRAD_WIDTH * POST_NEUR_PARALLEL;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [ADDR_WIDTH-1:0] cnt_r;
  logic [1:0]            mode_r;
  logic                  is_pos_r;
  logic [CNT_WIDTH-1:0]  pre_r;
  logic                  rd_pend;
  logic [WW-1:0]         rd_hold;

  logic [WW-1:0]         w_q, w_d;
  logic [GW-1:0]         g_q, g_d;
  logic                  w_cs, w_we, g_cs, g_we;
  logic [ADDR_WIDTH-1:0] w_addr, sweep_addr;
  logic                  sweeping, last, rd_accept;

  assign sweeping   = (state == ST_RD) || (state == ST_WR);
  assign sweep_addr = base_r + idx;
  assign last       = (idx == cnt_r - ADDR_WIDTH'(1));
  // START wins over a same-cycle read so the sweep latches a clean idle cycle.
  assign rd_accept  = (state == ST_IDLE) && !bus.start && bus.rd_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      base_r   <= '0;
      cnt_r    <= '0;
      mode_r   <= MODE_ACCUM;
      is_pos_r <= 1'b0;
      pre_r    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) begin
          base_r   <= bus.base_addr;
          cnt_r    <= bus.word_cnt;
          mode_r   <= bus.mode;
          is_pos_r <= bus.is_pos;
          pre_r    <= bus.pre_s_cnt;
          idx      <= '0;
          state    <= (bus.word_cnt == '0 || bus.mode == MODE_RSVD) ? ST_FIN : ST_RD;
        end
        ST_RD: state <= ST_WR;
        ST_WR: begin
          if (last) begin
            state <= ST_FIN;
          end else begin
            idx   <= idx + ADDR_WIDTH'(1);
            state <= ST_RD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_hold <= '0;
    end else begin
      rd_pend <= rd_accept;
      if (rd_pend) rd_hold <= w_q;
    end
  end

  assign w_cs   = sweeping || rd_accept;
  assign w_we   = (state == ST_WR) && (mode_r == MODE_APPLY);
  assign w_addr = (state == ST_IDLE) ? bus.rd_addr : sweep_addr;
  assign g_cs   = sweeping;
  assign g_we   = (state == ST_WR);

  for (genvar k = 0; k < POST_NEUR_PARALLEL; k++) begin : g_lane
    rmw_lane #(
      .WEIGHT_WIDTH(WEIGHT_WIDTH), .GRAD_WIDTH(GRAD_WIDTH), .CNT_WIDTH(CNT_WIDTH),
      .PROD_SHIFT(PROD_SHIFT), .LR_SHIFT(LR_SHIFT)
    ) u_lane (
      .mode    (mode_r),
      .is_pos  (is_pos_r),
      .pre_cnt (pre_r),
      .post_cnt(bus.post_s_cnt[k*CNT_WIDTH +: CNT_WIDTH]),
      .w_in    (w_q[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
      .g_in    (g_q[k*GRAD_WIDTH +: GRAD_WIDTH]),
      .w_out   (w_d[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
      .g_out   (g_d[k*GRAD_WIDTH +: GRAD_WIDTH])
    );
  end

  sram_synaptic_sim #(.WIDTH(WW), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_weight_bank (
    .clk(clk), .cs(w_cs), .we(w_we), .addr(w_addr), .d(w_d), .q(w_q)
  );

  sram_synaptic_sim #(.WIDTH(GW), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_grad_bank (
    .clk(clk), .cs(g_cs), .we(g_we), .addr(sweep_addr), .d(g_d), .q(g_q)
  );

  assign bus.post_idx  = idx;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_FIN);
  assign bus.err       = (state == ST_FIN) && (mode_r == MODE_RSVD);
  assign bus.rd_valid  = rd_pend;
  // Straight from the bank on the valid cycle, then held against later sweep reads.
  assign bus.rd_data   = rd_pend ? w_q : rd_hold;
  assign bus.dbg_state = state;

endmodule
